// File: rtl/pong_pkg.sv
// Shared constants for the pong pixel generator: colours, paddle columns, ball home position, direction encoding.
package pong_pkg;

   localparam logic [7:0] COL_BALL     = 8'hFF;
   localparam logic [7:0] COL_PADDLE_L = 8'hE0;
   localparam logic [7:0] COL_PADDLE_R = 8'h03;
   localparam logic [7:0] COL_NET      = 8'h92;
   localparam logic [7:0] COL_BG       = 8'h00;

   localparam logic [9:0] PADDLE_L_X0 = 10'd16;
   localparam logic [9:0] PADDLE_R_X0 = 10'd616;
   localparam logic [9:0] PADDLE_RST_Y = 10'd208;

   localparam logic [9:0] BALL_X0 = 10'd316;
   localparam logic [9:0] BALL_Y0 = 10'd236;

   localparam logic [9:0] NET_X0 = 10'd318;
   localparam logic [9:0] NET_X1 = 10'd321;

   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_x_e;
   typedef enum logic {DIR_UP   = 1'b0, DIR_DOWN  = 1'b1} dir_y_e;

endpackage

// File: rtl/pong_ball_ctrl.sv
// Ball/paddle game state, advanced once per frame_tick; score pulses are combinational in the tick cycle.
// Latency: new state visible the cycle after frame_tick; no backpressure.
module pong_ball_ctrl
   import pong_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int BALL_SIZE = 8,
   parameter int PADDLE_W  = 8,
   parameter int PADDLE_H  = 64,
   parameter int BALL_STEP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] pad_l_y,
   output logic [9:0] pad_r_y,
   output logic       score_l,
   output logic       score_r
);
   localparam logic [9:0] STEP    = 10'(BALL_STEP);
   localparam logic [9:0] SZ_M1   = 10'(BALL_SIZE - 1);
   localparam logic [9:0] PH_M1   = 10'(PADDLE_H - 1);
   localparam logic [9:0] PAD_MAX = 10'(V_ACTIVE - PADDLE_H);
   localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - BALL_SIZE);
   localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - BALL_SIZE);
   localparam logic [9:0] HIT_L_X = PADDLE_L_X0 + 10'(PADDLE_W);
   localparam logic [9:0] HIT_R_X = PADDLE_R_X0 - 10'(BALL_SIZE);

   logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [9:0] pad_l_q, pad_l_d, pad_r_q, pad_r_d;
   dir_x_e     dir_x_q, dir_x_d;
   dir_y_e     dir_y_q, dir_y_d;
   logic [9:0] cl_l, cl_r;
   logic       hit_l, hit_r, lose_l, lose_r;

   function automatic logic [9:0] clamp_pad(input logic [9:0] y);
      return (y > PAD_MAX) ? PAD_MAX : y;
   endfunction

   // Overlap tests only add, so nothing can wrap below zero.
   function automatic logic rows_overlap(input logic [9:0] by, input logic [9:0] top);
      return (by + SZ_M1 >= top) && (by <= top + PH_M1);
   endfunction

   always_comb begin
      cl_l   = clamp_pad(paddle_l_y);
      cl_r   = clamp_pad(paddle_r_y);
      hit_l  = (dir_x_q == DIR_LEFT) && (ball_x_q <= HIT_L_X + STEP) && rows_overlap(ball_y_q, cl_l);
      hit_r  = (dir_x_q == DIR_RIGHT) && (ball_x_q + STEP >= HIT_R_X) && rows_overlap(ball_y_q, cl_r);
      lose_l = (dir_x_q == DIR_LEFT) && !hit_l && (ball_x_q < STEP);
      lose_r = (dir_x_q == DIR_RIGHT) && !hit_r && (ball_x_q + STEP > X_MAX);

      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      pad_l_d  = pad_l_q;
      pad_r_d  = pad_r_q;

      if (frame_tick) begin
         pad_l_d = cl_l;
         pad_r_d = cl_r;

         if (dir_y_q == DIR_UP) begin
            if (ball_y_q < STEP) begin
               ball_y_d = '0;
               dir_y_d  = DIR_DOWN;
            end else begin
               ball_y_d = ball_y_q - STEP;
            end
         end else begin
            if (ball_y_q + STEP > Y_MAX) begin
               ball_y_d = Y_MAX;
               dir_y_d  = DIR_UP;
            end else begin
               ball_y_d = ball_y_q + STEP;
            end
         end

         if (hit_l) begin
            ball_x_d = HIT_L_X;
            dir_x_d  = DIR_RIGHT;
         end else if (hit_r) begin
            ball_x_d = HIT_R_X;
            dir_x_d  = DIR_LEFT;
         end else if (lose_l || lose_r) begin
            // A serve restarts from the centre; the vertical direction carries over.
            ball_x_d = BALL_X0;
            ball_y_d = BALL_Y0;
            dir_x_d  = (dir_x_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
         end else if (dir_x_q == DIR_LEFT) begin
            ball_x_d = ball_x_q - STEP;
         end else begin
            ball_x_d = ball_x_q + STEP;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ball_x_q <= BALL_X0;
         ball_y_q <= BALL_Y0;
         dir_x_q  <= DIR_RIGHT;
         dir_y_q  <= DIR_DOWN;
         pad_l_q  <= PADDLE_RST_Y;
         pad_r_q  <= PADDLE_RST_Y;
      end else begin
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         pad_l_q  <= pad_l_d;
         pad_r_q  <= pad_r_d;
      end
   end

   assign ball_x  = ball_x_q;
   assign ball_y  = ball_y_q;
   assign pad_l_y = pad_l_q;
   assign pad_r_y = pad_r_q;
   assign score_l = frame_tick & lose_r;
   assign score_r = frame_tick & lose_l;

endmodule

// File: rtl/pong_pixel_gen.sv
// Pong pixel generator: pixel counters, colour mux, 1-cycle aligned rgb/hs_out/vs_out; no backpressure.
// Optional dashed net enabled by defining PONG_CENTER_LINE_EN.
module pong_pixel_gen
   import pong_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int BALL_SIZE = 8,
   parameter int PADDLE_W  = 8,
   parameter int PADDLE_H  = 64,
   parameter int BALL_STEP = 2
) (
   input  logic       pixelClock,
   input  logic       reset,
   input  logic       hs,
   input  logic       vs,
   input  logic       bright,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [7:0] rgb,
   output logic       hs_out,
   output logic       vs_out,
   output logic       frame_tick,
   output logic       score_l,
   output logic       score_r
);
   localparam logic [9:0] PX_MAX   = 10'(H_ACTIVE - 1);
   localparam logic [9:0] PY_MAX   = 10'(V_ACTIVE - 1);
   localparam logic [9:0] SZ_M1    = 10'(BALL_SIZE - 1);
   localparam logic [9:0] PH_M1    = 10'(PADDLE_H - 1);
   localparam logic [9:0] PAD_L_X1 = PADDLE_L_X0 + 10'(PADDLE_W - 1);
   localparam logic [9:0] PAD_R_X1 = PADDLE_R_X0 + 10'(PADDLE_W - 1);

   logic [9:0] px_q, px_d, py_q, py_d;
   logic       hs_q, hs_d, vs_q, vs_d, vs_prev_q, vs_prev_d;
   logic       bright_q, bright_d, line_ok_q, line_ok_d;
   logic [7:0] rgb_q, rgb_d;
   logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
   logic       bright_rise, bright_fall;
   logic       in_ball, in_pad_l, in_pad_r;

   assign frame_tick = vs_prev_q & ~vs_q;

   pong_ball_ctrl #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .BALL_SIZE(BALL_SIZE),
      .PADDLE_W (PADDLE_W),
      .PADDLE_H (PADDLE_H),
      .BALL_STEP(BALL_STEP)
   ) u_ball (
      .clk       (pixelClock),
      .rst       (reset),
      .frame_tick(frame_tick),
      .paddle_l_y(paddle_l_y),
      .paddle_r_y(paddle_r_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .pad_l_y   (pad_l_y),
      .pad_r_y   (pad_r_y),
      .score_l   (score_l),
      .score_r   (score_r)
   );

   always_comb begin
      bright_rise = bright & ~bright_q;
      bright_fall = bright_q & ~bright;
      hs_d        = hs;
      vs_d        = vs;
      vs_prev_d   = vs_q;
      bright_d    = bright;
      // After reset nothing is drawn until a full line starts, so py cannot count a partial line.
      line_ok_d   = line_ok_q | bright_rise;

      px_d = '0;
      if (bright) px_d = (px_q == PX_MAX) ? px_q : px_q + 10'd1;

      py_d = py_q;
      if (frame_tick) py_d = '0;
      else if (bright_fall && line_ok_q && (py_q != PY_MAX)) py_d = py_q + 10'd1;

      in_ball  = (px_q >= ball_x) && (px_q <= ball_x + SZ_M1) &&
                 (py_q >= ball_y) && (py_q <= ball_y + SZ_M1);
      in_pad_l = (px_q >= PADDLE_L_X0) && (px_q <= PAD_L_X1) &&
                 (py_q >= pad_l_y) && (py_q <= pad_l_y + PH_M1);
      in_pad_r = (px_q >= PADDLE_R_X0) && (px_q <= PAD_R_X1) &&
                 (py_q >= pad_r_y) && (py_q <= pad_r_y + PH_M1);

      rgb_d = COL_BG;
      if (bright && (line_ok_q || bright_rise)) begin
         if (in_ball)       rgb_d = COL_BALL;
         else if (in_pad_l) rgb_d = COL_PADDLE_L;
         else if (in_pad_r) rgb_d = COL_PADDLE_R;
`ifdef PONG_CENTER_LINE_EN
         else if ((px_q >= NET_X0) && (px_q <= NET_X1) && !py_q[4]) rgb_d = COL_NET;
`endif
      end
   end

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         px_q      <= '0;
         py_q      <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         vs_prev_q <= 1'b1;
         bright_q  <= 1'b1;
         line_ok_q <= 1'b0;
         rgb_q     <= COL_BG;
      end else begin
         px_q      <= px_d;
         py_q      <= py_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         vs_prev_q <= vs_prev_d;
         bright_q  <= bright_d;
         line_ok_q <= line_ok_d;
         rgb_q     <= rgb_d;
      end
   end

   assign rgb    = rgb_q;
   assign hs_out = hs_q;
   assign vs_out = vs_q;

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Directed bench for pong_pixel_gen: pixel colour table plus multi-frame game trajectory sequences.
module tb_pong_pixel_gen;
   import pong_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       hs, vs, bright;
   logic [9:0] pl, pr;
   logic [7:0] rgb;
   logic       hs_out, vs_out, frame_tick, score_l, score_r;

   int total = 0;
   int bad   = 0;
   int ticks = 0;
   int sl_cnt = 0;
   int sr_cnt = 0;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] exp;
   } pix_vec_t;

   pix_vec_t vecs[16];

`ifdef PONG_CENTER_LINE_EN
   localparam logic [7:0] NET_EXP = 8'h92;
`else
   localparam logic [7:0] NET_EXP = 8'h00;
`endif

   always #5 clk = ~clk;

   pong_pixel_gen dut (
      .pixelClock(clk),
      .reset     (rst),
      .hs        (hs),
      .vs        (vs),
      .bright    (bright),
      .paddle_l_y(pl),
      .paddle_r_y(pr),
      .rgb       (rgb),
      .hs_out    (hs_out),
      .vs_out    (vs_out),
      .frame_tick(frame_tick),
      .score_l   (score_l),
      .score_r   (score_r)
   );

   always @(negedge clk) begin
      if (frame_tick) ticks++;
      if (score_l) sl_cnt++;
      if (score_r) sr_cnt++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; hs = 1'b1; vs = 1'b1; bright = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic short_lines(input int n);
      for (int i = 0; i < n; i++) begin
         bright = 1'b1; cyc();
         bright = 1'b0; cyc();
      end
   endtask

   // Skip n lines, then return the colour of column x on the following line.
   task automatic draw_px(input int x, input int n, output logic [7:0] c);
      short_lines(n);
      bright = 1'b1;
      repeat (x + 1) cyc();
      c = rgb;
      bright = 1'b0;
      cyc(); cyc();
   endtask

   task automatic frame();
      vs = 1'b0; cyc(); cyc();
      vs = 1'b1; cyc(); cyc();
   endtask

   initial begin
      logic [7:0] c;
      int t0, maxpx;

      vecs[0]  = '{0,   0,   8'h00};
      vecs[1]  = '{316, 236, 8'hFF};
      vecs[2]  = '{323, 243, 8'hFF};
      vecs[3]  = '{324, 243, 8'h00};
      vecs[4]  = '{315, 240, 8'h00};
      vecs[5]  = '{16,  208, 8'hE0};
      vecs[6]  = '{23,  271, 8'hE0};
      vecs[7]  = '{24,  240, 8'h00};
      vecs[8]  = '{16,  272, 8'h00};
      vecs[9]  = '{15,  240, 8'h00};
      vecs[10] = '{616, 208, 8'h03};
      vecs[11] = '{623, 271, 8'h03};
      vecs[12] = '{620, 207, 8'h00};
      vecs[13] = '{319, 0,   NET_EXP};
      vecs[14] = '{318, 16,  8'h00};
      vecs[15] = '{319, 240, 8'hFF};

      pl = 10'd208; pr = 10'd208;

      // Reset values, sampled while reset is held.
      rst = 1'b1; hs = 1'b0; vs = 1'b0; bright = 1'b1;
      repeat (3) cyc();
      chk("rst_rgb", rgb, 0);
      chk("rst_hs_out", hs_out, 1);
      chk("rst_vs_out", vs_out, 1);
      chk("rst_tick", frame_tick, 0);
      chk("rst_score_l", score_l, 0);
      chk("rst_score_r", score_r, 0);
      chk("rst_px", dut.px_q, 0);
      chk("rst_py", dut.py_q, 0);
      chk("rst_ball_x", dut.u_ball.ball_x_q, 316);
      chk("rst_ball_y", dut.u_ball.ball_y_q, 236);
      chk("rst_dir_x", int'(dut.u_ball.dir_x_q), 1);
      chk("rst_dir_y", int'(dut.u_ball.dir_y_q), 1);
      chk("rst_pad_l", dut.u_ball.pad_l_q, 208);
      chk("rst_pad_r", dut.u_ball.pad_r_q, 208);
      hs = 1'b1; vs = 1'b1; bright = 1'b0;
      rst = 1'b0;
      cyc();

      // hs/vs delay of exactly one cycle.
      hs = 1'b0;
      chk("hs_before_edge", hs_out, 1);
      cyc();
      chk("hs_delayed", hs_out, 0);
      hs = 1'b1;
      cyc();
      chk("hs_return", hs_out, 1);

      // Colour table against the reset game state.
      for (int i = 0; i < 16; i++) begin
         do_reset();
         draw_px(vecs[i].x, vecs[i].y, c);
         chk($sformatf("pix_%0d_%0d", vecs[i].x, vecs[i].y), c, vecs[i].exp);
         chk($sformatf("blank_%0d", i), rgb, 0);
      end

      // Counters: one tick per vs fall, py saturates, px saturates per line.
      do_reset();
      t0 = ticks;
      vs = 1'b0;
      chk("tick_pre", frame_tick, 0);
      cyc();
      chk("tick_on", frame_tick, 1);
      cyc();
      chk("tick_off", frame_tick, 0);
      vs = 1'b1;
      cyc();
      short_lines(500);
      chk("py_sat", dut.py_q, 479);
      for (int ln = 0; ln < 3; ln++) begin
         maxpx = 0;
         bright = 1'b1;
         for (int i = 0; i < 700; i++) begin
            cyc();
            if (int'(dut.px_q) > maxpx) maxpx = int'(dut.px_q);
         end
         chk($sformatf("px_max_line%0d", ln), maxpx, 639);
         chk($sformatf("px_hold_line%0d", ln), dut.px_q, 639);
         bright = 1'b0;
         cyc(); cyc();
         chk($sformatf("px_clear_line%0d", ln), dut.px_q, 0);
      end
      chk("one_tick_per_frame", ticks - t0, 1);
      frame();
      chk("py_resync", dut.py_q, 0);

      // Game trajectory from reset with compressed frames.
      do_reset();
      pl = 10'd140; pr = 10'd1000;
      for (int k = 1; k <= 902; k++) begin
         frame();
         case (k)
            146: begin
               chk("f146_x", dut.u_ball.ball_x_q, 608);
               chk("f146_dx", int'(dut.u_ball.dir_x_q), 0);
               chk("f146_y", dut.u_ball.ball_y_q, 418);
               chk("f146_pad_r_clamp", dut.u_ball.pad_r_q, 416);
               chk("f146_pad_l", dut.u_ball.pad_l_q, 140);
               draw_px(612, 420, c);
               chk("pix_ball_612_420", c, 8'hFF);
               draw_px(620, 58, c);
               chk("pix_pad_r_620_479", c, 8'h03);
            end
            353: begin chk("f353_y", dut.u_ball.ball_y_q, 4); chk("f353_dy", int'(dut.u_ball.dir_y_q), 0); end
            354: begin chk("f354_y", dut.u_ball.ball_y_q, 2); chk("f354_dy", int'(dut.u_ball.dir_y_q), 0); end
            355: begin chk("f355_y", dut.u_ball.ball_y_q, 0); chk("f355_dy", int'(dut.u_ball.dir_y_q), 0); end
            356: begin chk("f356_y", dut.u_ball.ball_y_q, 0); chk("f356_dy", int'(dut.u_ball.dir_y_q), 1); end
            357: begin chk("f357_y", dut.u_ball.ball_y_q, 2); chk("f357_dy", int'(dut.u_ball.dir_y_q), 1); end
            438: begin
               chk("f438_x", dut.u_ball.ball_x_q, 24);
               chk("f438_dx", int'(dut.u_ball.dir_x_q), 1);
               chk("f438_y", dut.u_ball.ball_y_q, 164);
               chk("f438_no_score", sl_cnt + sr_cnt, 0);
               pl = 10'd300;
            end
            742: begin
               chk("f742_x", dut.u_ball.ball_x_q, 632);
               chk("f742_score_l", sl_cnt, 0);
            end
            743: begin
               chk("f743_score_l", sl_cnt, 1);
               chk("f743_x", dut.u_ball.ball_x_q, 316);
               chk("f743_y", dut.u_ball.ball_y_q, 236);
               chk("f743_dx", int'(dut.u_ball.dir_x_q), 0);
               chk("f743_dy", int'(dut.u_ball.dir_y_q), 0);
            end
            901: begin
               chk("f901_x", dut.u_ball.ball_x_q, 0);
               chk("f901_score_r", sr_cnt, 0);
            end
            902: begin
               chk("f902_score_r", sr_cnt, 1);
               chk("f902_score_l", sl_cnt, 1);
               chk("f902_x", dut.u_ball.ball_x_q, 316);
               chk("f902_y", dut.u_ball.ball_y_q, 236);
               chk("f902_dx", int'(dut.u_ball.dir_x_q), 1);
               chk("f902_dy", int'(dut.u_ball.dir_y_q), 1);
            end
            default: ;
         endcase
      end

      // Reset pulse in the middle of a frame.
      do_reset();
      frame();
      short_lines(100);
      bright = 1'b1;
      repeat (300) cyc();
      chk("mid_px", dut.px_q, 300);
      chk("mid_py", dut.py_q, 100);
      hs = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_px", dut.px_q, 0);
      chk("mid_rst_py", dut.py_q, 0);
      chk("mid_rst_rgb", rgb, 0);
      chk("mid_rst_ball_x", dut.u_ball.ball_x_q, 316);
      chk("mid_rst_ball_y", dut.u_ball.ball_y_q, 236);
      cyc();
      chk("mid_rst_hs_out", hs_out, 1);
      chk("mid_rst_vs_out", vs_out, 1);
      rst = 1'b0;
      cyc();
      chk("mid_rel_hs_out", hs_out, 0);
      hs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("mid_rel_rgb%0d", i), rgb, 0);
      end
      bright = 1'b0;
      cyc(); cyc();
      chk("mid_partial_line_py", dut.py_q, 0);
      bright = 1'b1;
      cyc();
      chk("mid_new_line_px", dut.px_q, 1);
      bright = 1'b0;
      cyc(); cyc();
      chk("mid_new_line_py", dut.py_q, 1);
      t0 = ticks;
      frame();
      chk("mid_tick_resume", ticks - t0, 1);
      chk("mid_py_resync", dut.py_q, 0);
      chk("mid_ball_after_tick", dut.u_ball.ball_x_q, 318);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
